// File: rtl/ad7490_slave_model_if.sv
// Avalon-MM control port and AD7490 serial pins of the AD7490 slave model.
interface ad7490_slave_model_if;
  logic [31:0] avs_ctrl_writedata;
  logic [31:0] avs_ctrl_readdata;
  logic [3:0]  avs_ctrl_byteenable;
  logic [3:0]  avs_ctrl_address;
  logic        avs_ctrl_write;
  logic        avs_ctrl_read;
  logic        avs_ctrl_waitrequest;
  logic        SCLK;
  logic        SDI;
  logic        SDO;
  logic        SDO_oe;
  logic        nCS;

  modport slave (
    input  avs_ctrl_writedata, avs_ctrl_byteenable, avs_ctrl_address,
    input  avs_ctrl_write, avs_ctrl_read, SCLK, SDI, nCS,
    output avs_ctrl_readdata, avs_ctrl_waitrequest, SDO, SDO_oe
  );

  modport master (
    output avs_ctrl_writedata, avs_ctrl_byteenable, avs_ctrl_address,
    output avs_ctrl_write, avs_ctrl_read, SCLK, SDI, nCS,
    input  avs_ctrl_readdata, avs_ctrl_waitrequest, SDO, SDO_oe
  );
endinterface

// File: rtl/ad7490_slave_model.sv
// AD7490 serial-side emulator: oversamples SCLK/nCS/SDI on MCLK, stores control
// writes from the master and returns {ADD, sample} frames loaded over Avalon-MM.
module ad7490_slave_model #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [10:0] CTRL_RESET  = 11'h031
) (
  input logic                  csi_MCLK_clk,
  input logic                  rsi_MRST_reset,
  ad7490_slave_model_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_ncs_sync, r_sdi_sync;
  logic                   r_sclk_d, r_ncs_d;
  logic                   w_sclk_s, w_ncs_s, w_sdi_s;
  logic                   w_sclk_fall, w_ncs_fall, w_ncs_rise;

  state_t      r_state, w_state_nxt;
  logic        w_start, w_shift, w_end_done, w_end_abort;
  logic [4:0]  r_bit_cnt;
  logic [15:0] r_out_shift, r_in_shift;
  logic        r_sdo, r_sdo_oe;
  logic [10:0] r_ctrl;
  logic [15:0] r_frame_cnt, r_abort_cnt;
  logic [11:0] r_sample [16];
  logic [31:0] r_readdata, w_rdata;
  logic [3:0]  w_add;
  logic [11:0] w_sel, w_coded;
  logic [15:0] w_frame_word;
  logic        w_unused;

  // nCS history resets low so a pin already high (or low) at reset release never
  // looks like a falling edge; a frame can only start on a fresh nCS fall.
  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      r_sclk_sync <= '0;
      r_ncs_sync  <= '0;
      r_sdi_sync  <= '0;
      r_sclk_d    <= 1'b0;
      r_ncs_d     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the previous stage.
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.SCLK};
      r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], bus.nCS};
      r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0], bus.SDI};
      r_sclk_d    <= w_sclk_s;
      r_ncs_d     <= w_ncs_s;
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_ncs_s     = r_ncs_sync[SYNC_STAGES-1];
  assign w_sdi_s     = r_sdi_sync[SYNC_STAGES-1];
  assign w_sclk_fall = r_sclk_d & ~w_sclk_s;
  assign w_ncs_fall  = r_ncs_d & ~w_ncs_s;
  assign w_ncs_rise  = ~r_ncs_d & w_ncs_s;

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) r_state <= IDLE;
    else                r_state <= w_state_nxt;
  end

  // nCS rise takes priority over a coincident SCLK fall.
  always_comb begin
    // NOTE: defaults first so no path through this block can infer a latch.
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift     = 1'b0;
    w_end_done  = 1'b0;
    w_end_abort = 1'b0;
    if (w_ncs_rise) begin
      w_state_nxt = IDLE;
      w_end_done  = (r_state == DONE);
      w_end_abort = (r_state == SHIFT);
    end else begin
      case (r_state)
        IDLE: if (w_ncs_fall) begin
          w_start     = 1'b1;
          w_state_nxt = SHIFT;
        end
        SHIFT: if (w_sclk_fall) begin
          w_shift = 1'b1;
          if (r_bit_cnt == 5'd15) w_state_nxt = DONE;
        end
        default: ;
      endcase
    end
  end

  assign w_add        = r_ctrl[9:6];
  assign w_sel        = r_sample[w_add];
  assign w_coded      = r_ctrl[0] ? w_sel : {~w_sel[11], w_sel[10:0]};
  assign w_frame_word = {w_add, w_coded};

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      r_bit_cnt   <= '0;
      r_out_shift <= '0;
      r_in_shift  <= '0;
      r_sdo       <= 1'b0;
      r_sdo_oe    <= 1'b0;
      r_ctrl      <= CTRL_RESET;
      r_frame_cnt <= '0;
      r_abort_cnt <= '0;
    end else begin
      if (w_start) begin
        r_bit_cnt   <= '0;
        r_out_shift <= w_frame_word;
        r_sdo       <= w_frame_word[15];
        r_sdo_oe    <= 1'b1;
      end
      if (w_shift) begin
        r_in_shift  <= {r_in_shift[14:0], w_sdi_s};
        r_bit_cnt   <= r_bit_cnt + 5'd1;
        r_out_shift <= {r_out_shift[14:0], 1'b0};
        r_sdo       <= (r_bit_cnt == 5'd15) ? 1'b0 : r_out_shift[14];
      end
      if (w_ncs_rise) begin
        r_sdo    <= 1'b0;
        r_sdo_oe <= 1'b0;
      end
      if (w_end_done) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
        if (r_in_shift[15]) r_ctrl <= r_in_shift[14:4];
      end
      if (w_end_abort) r_abort_cnt <= r_abort_cnt + 16'd1;
    end
  end

  // Sample pair k: byte lanes 0/1 -> ch 2k, lanes 2/3 -> ch 2k+1.
  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      // NOTE: the sample table is small and software expects zeros, so it is reset.
      for (int i = 0; i < 16; i++) r_sample[i] <= '0;
    end else if (bus.avs_ctrl_write && !bus.avs_ctrl_address[3]) begin
      if (bus.avs_ctrl_byteenable[0])
        r_sample[{bus.avs_ctrl_address[2:0], 1'b0}][7:0]  <= bus.avs_ctrl_writedata[7:0];
      if (bus.avs_ctrl_byteenable[1])
        r_sample[{bus.avs_ctrl_address[2:0], 1'b0}][11:8] <= bus.avs_ctrl_writedata[11:8];
      if (bus.avs_ctrl_byteenable[2])
        r_sample[{bus.avs_ctrl_address[2:0], 1'b1}][7:0]  <= bus.avs_ctrl_writedata[23:16];
      if (bus.avs_ctrl_byteenable[3])
        r_sample[{bus.avs_ctrl_address[2:0], 1'b1}][11:8] <= bus.avs_ctrl_writedata[27:24];
    end
  end

  always_comb begin
    w_rdata = '0;
    if (!bus.avs_ctrl_address[3])
      w_rdata = {4'b0, r_sample[{bus.avs_ctrl_address[2:0], 1'b1}],
                 4'b0, r_sample[{bus.avs_ctrl_address[2:0], 1'b0}]};
    else if (bus.avs_ctrl_address == 4'd8)
      w_rdata = {21'b0, r_ctrl};
    else if (bus.avs_ctrl_address == 4'd9)
      w_rdata = {r_abort_cnt, r_frame_cnt};
  end

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) r_readdata <= '0;
    else                r_readdata <= w_rdata;
  end

  assign bus.avs_ctrl_readdata    = r_readdata;
  assign bus.avs_ctrl_waitrequest = 1'b0;
  assign bus.SDO                  = r_sdo;
  assign bus.SDO_oe               = r_sdo_oe;

  assign w_unused = ^{bus.avs_ctrl_read, bus.avs_ctrl_writedata[31:28],
                      bus.avs_ctrl_writedata[15:12], r_out_shift[15]};

endmodule

// File: tb/tb_ad7490_slave_model.sv
// Directed bench for ad7490_slave_model: acts as the SPI master and Avalon host.
`timescale 1ns/1ps
module tb_ad7490_slave_model;

  localparam int HALF = 8;  // MCLK cycles per SCLK half period

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  ad7490_slave_model_if bus ();

  ad7490_slave_model #(.SYNC_STAGES(2), .CTRL_RESET(11'h031)) dut (
    .csi_MCLK_clk   (clk),
    .rsi_MRST_reset (rst),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic avs_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
    bus.avs_ctrl_address    = addr;
    bus.avs_ctrl_writedata  = data;
    bus.avs_ctrl_byteenable = be;
    bus.avs_ctrl_write      = 1'b1;
    @(negedge clk);
    bus.avs_ctrl_write      = 1'b0;
  endtask

  task automatic avs_read(input logic [3:0] addr, output logic [31:0] data);
    bus.avs_ctrl_address = addr;
    bus.avs_ctrl_read    = 1'b1;
    @(negedge clk);
    data = bus.avs_ctrl_readdata;
    bus.avs_ctrl_read    = 1'b0;
  endtask

  // SPI mode matching the AD7490: DOUT/DIN change after SCLK falls, sampled on falls.
  task automatic spi_frame(input logic [15:0] din, input int n_edges, input bit end_cs,
                           input int wr_at, input logic [3:0] wr_addr,
                           input logic [31:0] wr_data,
                           output logic [15:0] dout, output logic oe_mid);
    dout    = '0;
    bus.SDI = din[15];
    bus.nCS = 1'b0;
    wait_clks(HALF);
    oe_mid   = bus.SDO_oe;
    dout[15] = bus.SDO;
    for (int i = 0; i < n_edges; i++) begin
      bus.SCLK = 1'b0;
      wait_clks(HALF);
      if (i < 15) dout[14-i] = bus.SDO;
      if (i + 1 == wr_at) avs_write(wr_addr, wr_data, 4'hF);
      if (i < 15) bus.SDI = din[14-i];
      bus.SCLK = 1'b1;
      wait_clks(HALF);
    end
    if (end_cs) begin
      bus.nCS = 1'b1;
      wait_clks(HALF);
    end
  endtask

  logic [31:0] rd;
  logic [15:0] dout;
  logic        oe;

  initial begin
    bus.avs_ctrl_writedata  = '0;
    bus.avs_ctrl_byteenable = '0;
    bus.avs_ctrl_address    = '0;
    bus.avs_ctrl_write      = 1'b0;
    bus.avs_ctrl_read       = 1'b0;
    bus.SCLK = 1'b1;
    bus.SDI  = 1'b0;
    bus.nCS  = 1'b1;
    wait_clks(4);
    rst = 1'b0;
    wait_clks(4);

    avs_read(4'd8, rd);  check("reset_ctrl", rd, 32'h0000_0031);
    avs_read(4'd9, rd);  check("reset_counts", rd, 32'h0);
    check("reset_sdo", {31'b0, bus.SDO}, 32'h0);
    check("reset_oe", {31'b0, bus.SDO_oe}, 32'h0);

    // Channel 0, straight binary; nCS held after the 16th fall to see SDO park at 0.
    avs_write(4'd0, 32'h0000_0ABC, 4'hF);
    spi_frame(16'h0000, 16, 1'b0, -1, 4'd0, 32'h0, dout, oe);
    check("f1_dout", {16'b0, dout}, 32'h0000_0ABC);
    check("f1_oe_mid", {31'b0, oe}, 32'h1);
    check("f1_sdo_done", {31'b0, bus.SDO}, 32'h0);
    check("f1_oe_done", {31'b0, bus.SDO_oe}, 32'h1);
    bus.nCS = 1'b1;
    wait_clks(HALF);
    check("f1_oe_after", {31'b0, bus.SDO_oe}, 32'h0);
    avs_read(4'd9, rd);  check("f1_counts", rd, 32'h0000_0001);

    // Write ADD=5, PM=11, CODING=0; this frame still returns channel 0.
    spi_frame(16'h9700, 16, 1'b1, -1, 4'd0, 32'h0, dout, oe);
    check("f2_dout", {16'b0, dout}, 32'h0000_0ABC);
    avs_read(4'd8, rd);  check("f2_ctrl", rd, 32'h0000_0170);
    avs_write(4'd2, 32'h0123_0000, 4'hF);

    // READ-only frame: ctrl kept, channel 5 in twos complement.
    spi_frame(16'h1234, 16, 1'b1, -1, 4'd0, 32'h0, dout, oe);
    check("f3_dout", {16'b0, dout}, 32'h0000_5923);
    avs_read(4'd8, rd);  check("f3_ctrl", rd, 32'h0000_0170);
    spi_frame(16'h0000, 16, 1'b1, -1, 4'd0, 32'h0, dout, oe);
    check("f4_dout", {16'b0, dout}, 32'h0000_5923);

    // Abort after 8 falls with a WRITE pattern in flight.
    spi_frame(16'h9F00, 8, 1'b1, -1, 4'd0, 32'h0, dout, oe);
    check("abort_dout_hi", {24'b0, dout[15:8]}, 32'h0000_0059);
    avs_read(4'd8, rd);  check("abort_ctrl", rd, 32'h0000_0170);
    avs_read(4'd9, rd);  check("abort_counts", rd, 32'h0001_0004);
    spi_frame(16'h0000, 16, 1'b1, -1, 4'd0, 32'h0, dout, oe);
    check("f5_dout", {16'b0, dout}, 32'h0000_5923);
    avs_read(4'd9, rd);  check("f5_counts", rd, 32'h0001_0005);

    // Byte lane 2 only: ch5 low byte becomes 0x45, ch4 untouched.
    avs_write(4'd2, 32'hFF45_FFFF, 4'b0100);
    avs_read(4'd2, rd);  check("be_pair2", rd, 32'h0145_0000);
    avs_write(4'd8, 32'hFFFF_FFFF, 4'hF);
    avs_read(4'd8, rd);  check("ro_ctrl", rd, 32'h0000_0170);
    avs_write(4'd10, 32'hFFFF_FFFF, 4'hF);
    avs_read(4'd10, rd); check("unmapped", rd, 32'h0);

    // Back to ADD=0, CODING=1.
    spi_frame(16'h8310, 16, 1'b1, -1, 4'd0, 32'h0, dout, oe);
    check("f6_dout", {16'b0, dout}, 32'h0000_5945);
    avs_read(4'd8, rd);  check("f6_ctrl", rd, 32'h0000_0031);

    // Sample write after 4 falls: in-flight frame keeps the snapshot.
    spi_frame(16'h0000, 16, 1'b1, 4, 4'd0, 32'h0000_0555, dout, oe);
    check("f7_snapshot", {16'b0, dout}, 32'h0000_0ABC);
    spi_frame(16'h0000, 16, 1'b1, -1, 4'd0, 32'h0, dout, oe);
    check("f8_new", {16'b0, dout}, 32'h0000_0555);
    avs_read(4'd9, rd);  check("f8_counts", rd, 32'h0001_0008);

    // Reset after 6 falls with nCS still low.
    spi_frame(16'h0000, 6, 1'b0, -1, 4'd0, 32'h0, dout, oe);
    check("mid_oe", {31'b0, bus.SDO_oe}, 32'h1);
    rst = 1'b1;
    wait_clks(1);
    check("rst_sdo", {31'b0, bus.SDO}, 32'h0);
    check("rst_oe", {31'b0, bus.SDO_oe}, 32'h0);
    wait_clks(3);
    rst = 1'b0;
    wait_clks(HALF);
    check("rst_oe_cs_low", {31'b0, bus.SDO_oe}, 32'h0);
    avs_read(4'd9, rd);  check("rst_counts", rd, 32'h0);
    avs_read(4'd8, rd);  check("rst_ctrl", rd, 32'h0000_0031);
    avs_read(4'd0, rd);  check("rst_sample", rd, 32'h0);
    bus.nCS = 1'b1;
    wait_clks(HALF);

    // SCLK toggling with nCS high must not start or count anything.
    for (int i = 0; i < 3; i++) begin
      bus.SCLK = 1'b0; wait_clks(HALF);
      bus.SCLK = 1'b1; wait_clks(HALF);
    end
    avs_read(4'd9, rd);  check("idle_sclk_counts", rd, 32'h0);
    check("idle_oe", {31'b0, bus.SDO_oe}, 32'h0);

    avs_write(4'd0, 32'h0000_0321, 4'hF);
    spi_frame(16'h0000, 16, 1'b1, -1, 4'd0, 32'h0, dout, oe);
    check("fresh_dout", {16'b0, dout}, 32'h0000_0321);
    avs_read(4'd9, rd);  check("fresh_counts", rd, 32'h0000_0001);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
